// File: rtl/split_sched_pkg.sv
// ---------------------------------------------------------------------------
// split_sched_pkg
//   Shared types and constants for the two-requester polynomial splitter
//   scheduler (split_sched) and its round-robin arbiter (rr_arb2).
//
//   Contents:
//     state_t          scheduler FSM states (IDLE, LAUNCH, WAIT, DELIVER)
//     M_DEFAULT        default polynomial width (nine GF(2^16) coefficients)
//     N_REQ            number of requesting clients
//     TIMEOUT_DEFAULT  default WAIT-state abort limit (timeout build only)
//     CNT_W            width of the WAIT-state cycle counter
// ---------------------------------------------------------------------------
package split_sched_pkg;

  localparam int M_DEFAULT       = 144;
  localparam int N_REQ           = 2;
  localparam int TIMEOUT_DEFAULT = 64;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

endpackage : split_sched_pkg

// File: rtl/split_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-client round-robin winner selection, purely combinational. Shared by
//   the splitter scheduler and later shared ALU units.
//
//   Ports:
//     req     in  [1:0]  request levels of client 0 and client 1
//     last    in  1      index of the client served most recently
//     winner  out 1      index of the client to serve next
//
//   A lone request always wins; on a tie the client that was not served
//   last wins. With no request the output is 0 and must be ignored.
// ---------------------------------------------------------------------------
module rr_arb2
  import split_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic             winner
);

  // NOTE: every output of a combinational block gets a default before the
  // case; a path that leaves it unassigned would infer a latch.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule : rr_arb2

// File: rtl/split_sched.sv
// ---------------------------------------------------------------------------
// split_sched
//   Round-robin scheduler in front of the single shared polynomial splitter
//   (T(x) = T0(x)^2 + x*T1(x)^2). Picks one of two clients, launches the
//   splitter with that client's polynomial, waits for completion, latches
//   both fragments and strobes a one-cycle ack back to the winner.
//
//   Parameters:
//     M        polynomial width in bits
//     TIMEOUT  WAIT-state cycle limit before abort (timeout build only)
//
//   Ports:
//     clk           in   1      clock, all logic on posedge
//     rst           in   1      synchronous active-high reset
//     req           in   2      per-client request level, held until ack
//     poly_0        in   M      client 0 polynomial, stable while req[0]
//     poly_1        in   M      client 1 polynomial, stable while req[1]
//     ack           out  2      one-hot, one-cycle result strobe
//     first_out     out  M      latched first fragment (T0)
//     second_out    out  M      latched second fragment (T1)
//     err           out  1      valid with ack, 1 = splitter timed out
//     busy          out  1      high in every state except IDLE
//     split_start   out  1      one-cycle start pulse to the splitter
//     split_poly    out  M      registered polynomial to the splitter
//     split_first   in   M      splitter first fragment
//     split_second  in   M      splitter second fragment
//     split_done    in   1      splitter completion pulse
//
//   Build option:
//     SPLIT_SCHED_TIMEOUT_EN  when defined, an 8-bit counter aborts WAIT
//                             after TIMEOUT cycles with err=1 and zeroed
//                             fragments; otherwise WAIT is unbounded and
//                             err is tied low.
// ---------------------------------------------------------------------------
module split_sched
  import split_sched_pkg::*;
#(
  parameter int M       = M_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [0:M-1]     poly_0,
  input  logic [0:M-1]     poly_1,
  output logic [N_REQ-1:0] ack,
  output logic [0:M-1]     first_out,
  output logic [0:M-1]     second_out,
  output logic             err,
  output logic             busy,
  output logic             split_start,
  output logic [0:M-1]     split_poly,
  input  logic [0:M-1]     split_first,
  input  logic [0:M-1]     split_second,
  input  logic             split_done
);

  state_t state;
  state_t state_nxt;

  logic gnt;      // client owning the current transaction
  logic last;     // client served most recently (round-robin history)
  logic winner;   // arbiter choice, only meaningful in IDLE with req != 0
  logic expire;   // WAIT limit reached without split_done
  logic err_q;    // outcome of the transaction being delivered

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .last   (last),
    .winner (winner)
  );

`ifdef SPLIT_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Counter is 0 in the first WAIT cycle, so expiry in cycle TIMEOUT-1
  // places DELIVER exactly TIMEOUT cycles after WAIT was entered.
  assign expire = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // split_done takes priority over a coincident expiry.
      if (state == WAIT) begin
        if (split_done) begin
          err_q <= 1'b0;
        end else if (expire) begin
          err_q <= 1'b1;
        end
      end
    end
  end
`else
  assign expire = 1'b0;
  assign err_q  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ack         = '0;
    busy        = 1'b1;
    split_start = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        split_start = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        // A split_done seen in any other state is ignored, which also
        // discards the completion of a run abandoned by reset.
        if (split_done || expire) begin
          state_nxt = DELIVER;
        end
      end
      DELIVER: begin
        ack[gnt]  = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant/polynomial capture, fragment capture, round-robin
  // history. Fragments hold until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 1'b0;
      last       <= 1'b1;   // client 0 wins the first tie after reset
      split_poly <= '0;
      first_out  <= '0;
      second_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt        <= winner;
            split_poly <= winner ? poly_1 : poly_0;
          end
        end
        WAIT: begin
          if (split_done) begin
            first_out  <= split_first;
            second_out <= split_second;
          end else if (expire) begin
            first_out  <= '0;
            second_out <= '0;
          end
        end
        DELIVER: begin
          last <= gnt;
        end
        default: ;
      endcase
    end
  end

endmodule : split_sched

// File: tb/tb_split_sched.sv
// ---------------------------------------------------------------------------
// tb_split_sched
//   Directed bench for split_sched with a behavioural splitter model and a
//   scoreboard: stimulus pushes the expected start polynomial and the
//   expected ack record; a negedge monitor pops and compares whenever the
//   DUT pulses split_start or ack.
// ---------------------------------------------------------------------------
module tb_split_sched;
  import split_sched_pkg::*;

  localparam int M       = M_DEFAULT;
  localparam int LAT     = 18;
  localparam int TIMEOUT = TIMEOUT_DEFAULT;

  typedef struct {
    logic [1:0]   ack;
    logic [0:M-1] first;
    logic [0:M-1] second;
    logic         err;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [0:M-1] poly_0 = '0;
  logic [0:M-1] poly_1 = '0;
  logic [1:0]   ack;
  logic [0:M-1] first_out;
  logic [0:M-1] second_out;
  logic         err;
  logic         busy;
  logic         split_start;
  logic [0:M-1] split_poly;
  logic [0:M-1] split_first  = '0;
  logic [0:M-1] split_second = '0;
  logic         split_done   = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t         exp_q[$];
  logic [0:M-1] poly_q[$];
  int           ack_cycles[$];
  int           n_acks    = 0;
  int           n_starts  = 0;
  int           start_cyc = 0;

  // Splitter model controls (written by the stimulus process only).
  int model_lat  = LAT;
  bit model_mute = 1'b0;
  int inject_cnt = 0;

  split_sched #(.M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .poly_0       (poly_0),
    .poly_1       (poly_1),
    .ack          (ack),
    .first_out    (first_out),
    .second_out   (second_out),
    .err          (err),
    .busy         (busy),
    .split_start  (split_start),
    .split_poly   (split_poly),
    .split_first  (split_first),
    .split_second (split_second),
    .split_done   (split_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference fragment functions of the behavioural splitter.
  function automatic logic [0:M-1] frag0(input logic [0:M-1] p);
    return {p[M/2:M-1], p[0:M/2-1]};
  endfunction

  function automatic logic [0:M-1] frag1(input logic [0:M-1] p);
    return ~p ^ {(M/16){16'h5a3c}};
  endfunction

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural splitter: latches split_poly on split_start, pulses
  // split_done model_lat cycles later. Keeps running through DUT reset so a
  // stale completion can be observed. Also emits injected spurious pulses.
  int           inject_seen = 0;
  bit           pending     = 1'b0;
  int           mcnt        = 0;
  logic [0:M-1] mpoly       = '0;

  always @(posedge clk) begin
    #1;
    split_done = 1'b0;
    if (inject_seen != inject_cnt) begin
      inject_seen++;
      split_first  = {M{1'b1}};
      split_second = {(M/8){8'ha5}};
      split_done   = 1'b1;
    end else if (pending) begin
      mcnt--;
      if (mcnt == 0) begin
        pending = 1'b0;
        if (!model_mute) begin
          split_first  = frag0(mpoly);
          split_second = frag1(mpoly);
          split_done   = 1'b1;
        end
      end
    end else if (split_start) begin
      pending = 1'b1;
      mcnt    = model_lat;
      mpoly   = split_poly;
    end
  end

  // Monitor: compares every start and every ack against the scoreboard.
  always @(negedge clk) begin
    if (split_start) begin
      n_starts++;
      start_cyc = cyc;
      check("start_expected", poly_q.size() > 0, 1'b1);
      if (poly_q.size() > 0) begin
        check("split_poly", split_poly, poly_q.pop_front());
      end
    end
    if (ack != 2'b00) begin
      exp_t e;
      n_acks++;
      ack_cycles.push_back(cyc);
      check("ack_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_client", ack, e.ack);
        check("first_out", first_out, e.first);
        check("second_out", second_out, e.second);
        check("err", err, e.err);
        check("start_to_ack", cyc - start_cyc, e.lat);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_tx(input int client, input logic [0:M-1] p, input int lat, input bit timed_out);
    exp_t e;
    e.ack    = (client == 0) ? 2'b01 : 2'b10;
    e.first  = timed_out ? '0 : frag0(p);
    e.second = timed_out ? '0 : frag1(p);
    e.err    = timed_out;
    e.lat    = lat;
    poly_q.push_back(p);
    exp_q.push_back(e);
  endtask

  task automatic wait_acks(input int target, input int budget);
    int k = 0;
    while (n_acks < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("ack_arrived", n_acks >= target, 1'b1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (n_starts < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("start_arrived", n_starts >= target, 1'b1);
  endtask

  initial begin
    logic [0:M-1] p0, p1, p2, p3;
    int target, req_cyc, base;
    p0 = 144'h1 << 128;
    p1 = 144'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_1357;
    p2 = 144'hffff_0000_ffff_0000_1111_2222_3333_4444_5555;
    p3 = 144'h8000_0000_0000_0000_0000_0000_0000_0000_0001;

    // Reset state.
    step(2);
    check("rst_ack", ack, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_start", split_start, 1'b0);
    check("rst_poly", split_poly, '0);
    check("rst_first", first_out, '0);
    check("rst_second", second_out, '0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    // Single request from client 0.
    poly_0 = p0;
    expect_tx(0, p0, LAT + 1, 1'b0);
    target  = n_acks + 1;
    req     = 2'b01;
    req_cyc = cyc;
    wait_starts(n_starts + 1, 10);
    check("req_to_start", start_cyc - req_cyc, 1);
    check("busy_in_flight", busy, 1'b1);
    wait_acks(target, 100);
    req = 2'b00;
    step(2);
    check("hold_first", first_out, frag0(p0));
    check("idle_busy", busy, 1'b0);

    // Tie after reset: client 0 first, then client 1.
    rst = 1'b1;
    step(1);
    rst    = 1'b0;
    poly_1 = p1;
    base   = ack_cycles.size();
    expect_tx(0, p0, LAT + 1, 1'b0);
    expect_tx(1, p1, LAT + 1, 1'b0);
    req = 2'b11;
    wait_acks(n_acks + 1, 100);
    req = 2'b10;
    wait_acks(n_acks + 1, 100);
    req = 2'b00;
    if (ack_cycles.size() >= base + 2) begin
      check("tie_ack_gap", ack_cycles[base+1] - ack_cycles[base], LAT + 3);
    end

    // Fairness: both held for six transactions.
    for (int i = 0; i < 6; i++) begin
      expect_tx(i % 2, (i % 2 == 0) ? p0 : p1, LAT + 1, 1'b0);
    end
    target = n_acks + 6;
    req    = 2'b11;
    wait_acks(target, 6 * 40);
    req = 2'b00;

    // Spurious split_done in IDLE.
    step(2);
    inject_cnt++;
    step(4);
    check("spur_first", first_out, frag0(p1));
    check("spur_second", second_out, frag1(p1));
    check("spur_busy", busy, 1'b0);
    check("spur_start", split_start, 1'b0);

    // Reset five cycles into WAIT; the abandoned run's done must be ignored.
    poly_0 = p2;
    poly_q.push_back(p2);
    req = 2'b01;
    wait_starts(n_starts + 1, 10);
    step(5);
    check("midrun_busy", busy, 1'b1);
    rst = 1'b1;
    req = 2'b00;
    step(1);
    check("mrst_ack", ack, 2'b00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_start", split_start, 1'b0);
    check("mrst_poly", split_poly, '0);
    check("mrst_first", first_out, '0);
    check("mrst_second", second_out, '0);
    check("mrst_err", err, 1'b0);
    rst = 1'b0;
    step(LAT + 4);
    check("stale_first", first_out, '0);
    check("stale_busy", busy, 1'b0);

    // Recovery: lone request from client 1.
    poly_1 = p3;
    expect_tx(1, p3, LAT + 1, 1'b0);
    req = 2'b10;
    wait_acks(n_acks + 1, 100);
    req = 2'b00;
    step(2);

`ifdef SPLIT_SCHED_TIMEOUT_EN
    // Splitter never answers: abort with err and zeroed fragments.
    model_mute = 1'b1;
    model_lat  = TIMEOUT;
    expect_tx(0, p2, TIMEOUT + 1, 1'b1);
    req = 2'b01;
    wait_acks(n_acks + 1, 200);
    req = 2'b00;
    step(2);
    // Completion in the expiry cycle wins.
    model_mute = 1'b0;
    expect_tx(1, p3, TIMEOUT + 1, 1'b0);
    req = 2'b10;
    wait_acks(n_acks + 1, 200);
    req = 2'b00;
    step(2);
    model_lat = LAT;
`endif

    check("exp_drained", exp_q.size(), 0);
    check("poly_drained", poly_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_split_sched
